// File: rtl/sound_event_queue_if.sv
// Sound-event request bus between game logic (master) and the event queue (slave).
interface sound_event_queue_if #(
  parameter int SAMPLE_BITS = 3,
  parameter int EVENT_COUNT = 5
);
  logic [EVENT_COUNT-1:0] EVENTS;
  logic                   MUTE;
  logic [SAMPLE_BITS-1:0] SELECT;
  logic                   TRIGGER;
  logic                   BUSY;

  modport master (output EVENTS, MUTE, input SELECT, TRIGGER, BUSY);
  modport slave  (input EVENTS, MUTE, output SELECT, TRIGGER, BUSY);
endinterface

// File: rtl/sound_event_queue.sv
// Latches one-cycle sound-event pulses and issues one prioritised sample start at a time,
// followed by a hold-off window that only a strictly higher-priority request may pre-empt.
module sound_event_queue #(
  parameter int SAMPLE_BITS = 3,
  parameter int EVENT_COUNT = 5,
  parameter int HOLD_CYCLES = 1250000,
  parameter int HOLD_BITS   = 21
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sound_event_queue_if.slave     bus
);
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLD_CYCLES - 1);

  state_t                 r_state;
  logic [EVENT_COUNT-1:0] r_pend;
  logic [SAMPLE_BITS-1:0] r_select;
  logic [SAMPLE_BITS-1:0] r_cur;
  logic [HOLD_BITS-1:0]   r_cnt;
  logic                   r_trigger;
  logic                   r_busy;

  logic [SAMPLE_BITS-1:0] w_cand;
  logic                   w_any;
  logic                   w_issue;
  logic [EVENT_COUNT-1:0] w_clr;
  logic [EVENT_COUNT-1:0] w_pend_nxt;

  // Candidate comes from registered pending bits only; lowest index wins.
  always_comb begin
    w_cand = '0;
    for (int i = EVENT_COUNT - 1; i >= 0; i--) begin
      if (r_pend[i]) w_cand = SAMPLE_BITS'(i);
    end
    w_any   = |r_pend;
    w_issue = !bus.MUTE && w_any && ((r_state == S_IDLE) || (w_cand < r_cur));
    w_clr   = w_issue ? (EVENT_COUNT'(1) << w_cand) : '0;
    // Clearing after the OR absorbs a same-index pulse arriving in the issue cycle.
    w_pend_nxt = bus.MUTE ? '0 : ((r_pend | bus.EVENTS) & ~w_clr);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_select  <= '0;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_trigger <= w_issue;
      if (w_issue) begin
        r_select <= w_cand;
        r_cur    <= w_cand;
        r_cnt    <= HOLD_LOAD;
        r_state  <= S_HOLD;
        r_busy   <= 1'b1;
      end else if (r_state == S_HOLD) begin
        if (r_cnt == '0) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - HOLD_BITS'(1);
        end
      end
    end
  end

  assign bus.SELECT  = r_select;
  assign bus.TRIGGER = r_trigger;
  assign bus.BUSY    = r_busy;
endmodule

// File: tb/tb_sound_event_queue.sv
// Directed bench for sound_event_queue with HOLD_CYCLES=8; edges are counted from reset release.
module tb_sound_event_queue;
  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 CLK = ~CLK;

  sound_event_queue_if #(.SAMPLE_BITS(3), .EVENT_COUNT(5)) bus ();

  sound_event_queue #(
    .SAMPLE_BITS(3), .EVENT_COUNT(5), .HOLD_CYCLES(8), .HOLD_BITS(3)
  ) u_dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with ev sampled on it; TRIGGER checked just after.
  task automatic tick(input logic [4:0] ev, input logic exp_trig);
    bus.EVENTS = ev;
    @(posedge CLK);
    #1;
    cyc++;
    bus.EVENTS = '0;
    chk($sformatf("trig@%0d", cyc), 32'(bus.TRIGGER), 32'(exp_trig));
  endtask

  // Idle edges up to and including edge upto; a trigger is expected only on the last one if last_trig.
  task automatic run(input int upto, input logic last_trig);
    while (cyc < upto) tick(5'b0, (cyc + 1 == upto) ? last_trig : 1'b0);
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    RESET = 1'b1;
    #2;
    chk({tag, "_sel"},  32'(bus.SELECT),  32'd0);
    chk({tag, "_trig"}, 32'(bus.TRIGGER), 32'd0);
    chk({tag, "_busy"}, 32'(bus.BUSY),    32'd0);
    RESET = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.EVENTS = '0;
    bus.MUTE   = 1'b0;
    RESET      = 1'b1;
    #12;
    chk("rst_sel",  32'(bus.SELECT),  32'd0);
    chk("rst_trig", 32'(bus.TRIGGER), 32'd0);
    chk("rst_busy", 32'(bus.BUSY),    32'd0);
    RESET = 1'b0;
    cyc = 0;

    // Single pulse on event 2
    run(9, 0);
    tick(5'b00100, 0);
    run(11, 1);
    chk("s1_sel", 32'(bus.SELECT), 32'd2);
    chk("s1_busy11", 32'(bus.BUSY), 32'd1);
    run(18, 0);
    chk("s1_busy18", 32'(bus.BUSY), 32'd1);
    run(19, 0);
    chk("s1_busy19", 32'(bus.BUSY), 32'd0);
    run(22, 0);
    chk("s1_sel_hold", 32'(bus.SELECT), 32'd2);

    // Simultaneous events 1, 2, 4
    async_reset("r2");
    run(9, 0);
    tick(5'b10110, 0);
    run(11, 1);
    chk("s2_sel11", 32'(bus.SELECT), 32'd1);
    run(19, 0);
    chk("s2_busy19", 32'(bus.BUSY), 32'd0);
    run(20, 1);
    chk("s2_sel20", 32'(bus.SELECT), 32'd2);
    run(29, 1);
    chk("s2_sel29", 32'(bus.SELECT), 32'd4);
    run(40, 0);
    chk("s2_busy40", 32'(bus.BUSY), 32'd0);

    // Pre-emption by event 0 during event 3 hold
    async_reset("r3");
    run(9, 0);
    tick(5'b01000, 0);
    run(11, 1);
    chk("s3_sel11", 32'(bus.SELECT), 32'd3);
    run(13, 0);
    tick(5'b00001, 0);
    run(15, 1);
    chk("s3_sel15", 32'(bus.SELECT), 32'd0);
    run(22, 0);
    chk("s3_busy22", 32'(bus.BUSY), 32'd1);
    run(23, 0);
    chk("s3_busy23", 32'(bus.BUSY), 32'd0);
    run(26, 0);

    // Lower-priority event 4 waits out the hold
    async_reset("r4");
    run(9, 0);
    tick(5'b01000, 0);
    run(11, 1);
    run(13, 0);
    tick(5'b10000, 0);
    run(20, 1);
    chk("s4_sel20", 32'(bus.SELECT), 32'd4);
    run(30, 0);

    // Merge of repeated pulses
    async_reset("r5");
    run(9, 0);
    tick(5'b00100, 0);
    run(11, 1);
    tick(5'b00100, 0);
    tick(5'b00100, 0);
    run(20, 1);
    chk("s5_sel20", 32'(bus.SELECT), 32'd2);
    run(30, 0);

    // Same-index pulse in the issue cycle is absorbed
    async_reset("r6");
    run(9, 0);
    tick(5'b00100, 0);
    tick(5'b00100, 1);
    run(24, 0);

    // MUTE discards requests
    async_reset("r7");
    run(4, 0);
    bus.MUTE = 1'b1;
    run(9, 0);
    tick(5'b00100, 0);
    run(19, 0);
    tick(5'b00001, 0);
    run(30, 0);
    bus.MUTE = 1'b0;
    run(40, 0);
    chk("s7_busy", 32'(bus.BUSY), 32'd0);
    tick(5'b00010, 0);
    run(42, 1);
    chk("s7_sel", 32'(bus.SELECT), 32'd1);

    // Reset during the trigger pulse
    async_reset("r8");
    run(9, 0);
    tick(5'b01000, 0);
    run(11, 1);
    chk("s8_sel_pre", 32'(bus.SELECT), 32'd3);
    async_reset("r8_mid");
    run(12, 0);

    // Reset mid-hold with event 1 pending
    async_reset("r9");
    run(9, 0);
    tick(5'b00011, 0);
    run(11, 1);
    chk("s9_sel", 32'(bus.SELECT), 32'd0);
    run(13, 0);
    chk("s9_busy_pre", 32'(bus.BUSY), 32'd1);
    async_reset("r9_mid");
    run(20, 0);
    tick(5'b00010, 0);
    run(22, 1);
    chk("s9_sel_new", 32'(bus.SELECT), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
